// File: rtl/div_iter_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_iter_unit
// Description : Iterative radix-2 restoring divider (DIV/DIVU), one quotient
//               bit per clock. Acts as the responder to a start/ready divide
//               handshake. The operands are latched when start is first
//               accepted. The unit runs WIDTH iterations, applies sign
//               correction, and then presents {remainder, quotient} with
//               ready held high until the requester releases start.
// Ports       : clk, rst (sync, active-high)
//               signed_div_i  - 1 = signed divide, 0 = unsigned
//               opdata1_i     - dividend
//               opdata2_i     - divisor
//               start_i       - request, held high until ready_o observed
//               annul_i       - abort the current operation
//               result_o      - {remainder[2W-1:W], quotient[W-1:0]}
//               ready_o       - result valid
//               busy_o        - divider working (calculating / by-zero)
// Revision    : 1.0 - initial release
// ============================================================================
module div_iter_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] c_last_iter = CW'(WIDTH - 1);
    localparam logic [CW-1:0] c_cnt_one   = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BYZERO = 2'd1,
        S_CALC   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t               r_state;
    logic [2*WIDTH-1:0]   r_acc;       // {partial remainder, dividend/quotient}
    logic [WIDTH-1:0]     r_divisor;   // magnitude of the divisor
    logic                 r_sign_q;
    logic                 r_sign_r;
    logic [CW-1:0]        r_cnt;

    // Operand magnitudes. The most negative value maps to 2^(W-1), which is
    // still representable as an unsigned W-bit number.
    logic             w_neg1;
    logic             w_neg2;
    logic [WIDTH-1:0] w_op1_abs;
    logic [WIDTH-1:0] w_op2_abs;

    assign w_neg1    = signed_div_i & opdata1_i[WIDTH-1];
    assign w_neg2    = signed_div_i & opdata2_i[WIDTH-1];
    assign w_op1_abs = w_neg1 ? -opdata1_i : opdata1_i;
    assign w_op2_abs = w_neg2 ? -opdata2_i : opdata2_i;

    // Trial subtraction on the upper W+1 bits of the left-shifted accumulator.
    // The partial remainder is always below the divisor, so after the shift it
    // is below 2*divisor and the W+1-bit difference has a meaningful sign bit.
    logic [WIDTH:0]       w_upper;
    logic [WIDTH:0]       w_diff;
    logic [2*WIDTH-1:0]   w_acc_next;

    assign w_upper    = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff     = w_upper - {1'b0, r_divisor};
    assign w_acc_next = w_diff[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                      : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    // Sign-corrected result: quotient truncates toward zero, remainder takes
    // the sign of the dividend.
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;

    assign w_quo = r_sign_q ? -r_acc[WIDTH-1:0]       : r_acc[WIDTH-1:0];
    assign w_rem = r_sign_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_divisor <= '0;
            r_sign_q  <= 1'b0;
            r_sign_r  <= 1'b0;
            r_cnt     <= '0;
            result_o  <= '0;
            ready_o   <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    ready_o <= 1'b0;
                    busy_o  <= 1'b0;
                    if (start_i && !annul_i) begin
                        r_acc     <= {{WIDTH{1'b0}}, w_op1_abs};
                        r_divisor <= w_op2_abs;
                        r_sign_q  <= w_neg1 ^ w_neg2;
                        r_sign_r  <= w_neg1;
                        r_cnt     <= '0;
                        r_state   <= (opdata2_i == '0) ? S_BYZERO : S_CALC;
                    end
                end

                S_BYZERO: begin
                    if (annul_i) begin
                        busy_o  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        // Zero divisor yields an all-zero result.
                        busy_o   <= 1'b1;
                        r_acc    <= '0;
                        r_sign_q <= 1'b0;
                        r_sign_r <= 1'b0;
                        r_state  <= S_DONE;
                    end
                end

                S_CALC: begin
                    if (annul_i) begin
                        busy_o  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        busy_o <= 1'b1;
                        r_acc  <= w_acc_next;
                        r_cnt  <= r_cnt + c_cnt_one;
                        if (r_cnt == c_last_iter) begin
                            r_state <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    busy_o <= 1'b0;
                    if (annul_i || !start_i) begin
                        // result_o keeps its last value until the next completion.
                        ready_o <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        // Accumulator is frozen here, so rewriting is harmless.
                        ready_o  <= 1'b1;
                        result_o <= {w_rem, w_quo};
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_iter_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_iter_unit
// Description : Self-checking bench for div_iter_unit (WIDTH = 32). Covers
//               directed cases and randomized operations. The reference model
//               uses plain 64-bit integer division.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_iter_unit;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int n_pass  = 0;
    int n_total = 0;

    div_iter_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Reference: integer division on 64-bit signed values. SystemVerilog '/'
    // truncates toward zero and '%' follows the dividend's sign.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // One full handshake: raise start, wait for ready (bounded), check latency,
    // result and busy, hold start for 'hold' extra cycles, then release start.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [63:0] exp, input int hold);
        int  since;
        int  busy_cnt;
        int  lat;
        bit  got;
        lat      = (b == 32'd0) ? 2 : 33;
        since    = -1;
        busy_cnt = 0;
        got      = 1'b0;
        @(negedge clk);
        start_i      = 1'b1;
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = s;
        while (!got && since < 60) begin
            @(posedge clk);
            #1;
            since++;
            if (since == 0) begin
                // Operands are latched now; later changes must be ignored.
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = 1'($urandom_range(0, 1));
            end
            if (busy_o) busy_cnt++;
            if (ready_o) got = 1'b1;
        end
        check("latency", 64'(since), 64'(lat));
        check("result", result_o, exp);
        if (b == 32'd0) check("byzero_busy_cycles", 64'(busy_cnt), 64'd1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_ready", 64'(ready_o), 64'd1);
            check("hold_result", result_o, exp);
        end
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check("ready_drop", 64'(ready_o), 64'd0);
        check("result_keep", result_o, exp);
    endtask

    initial begin
        logic [31:0] a, b;
        logic        s;
        int          ready_seen;

        rst          = 1'b1;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_busy", 64'(busy_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        rst = 1'b0;

        // Directed cases with hand-derived expectations.
        do_op(32'h64,       32'h7,        1'b0, 64'h00000002_0000000E, 0);
        do_op(32'hFFFFFFF9, 32'h2,        1'b1, 64'hFFFFFFFF_FFFFFFFD, 0);
        do_op(32'hFFFFFFF9, 32'h2,        1'b0, 64'h00000001_7FFFFFFC, 0);
        do_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 0);
        do_op(32'h80000000, 32'h1,        1'b1, 64'h00000000_80000000, 0);
        do_op(32'h7,        32'hFFFFFFF9, 1'b1, 64'h00000000_FFFFFFFF, 5);
        do_op(32'h12345678, 32'h0,        1'b1, 64'h0,                 0);

        // Annul at iteration 10: no ready, unit returns to idle.
        @(negedge clk);
        start_i      = 1'b1;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        signed_div_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        check("annul_busy", 64'(busy_o), 64'd0);
        ready_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (ready_o) ready_seen++;
        end
        check("annul_no_ready", 64'(ready_seen), 64'd0);
        do_op(32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 0);

        // Reset in the middle of a calculation clears every output.
        @(negedge clk);
        start_i   = 1'b1;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        rst     = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_ready", 64'(ready_o), 64'd0);
        check("midrst_busy", 64'(busy_o), 64'd0);
        check("midrst_result", result_o, 64'd0);
        rst = 1'b0;

        // Randomized back-to-back operations.
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'd1;
                2:       b = 32'hFFFFFFFF;
                3:       b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       a = 32'h80000000;
                1:       a = $urandom_range(0, 100);
                default: a = $urandom;
            endcase
            s = 1'($urandom_range(0, 1));
            do_op(a, b, s, model(a, b, s), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_iter_unit.md
Name: div_iter_unit

Overview:
- Iterative radix-2 restoring divider, one quotient bit per cycle.
- Acts as the responder to the EX stage's start/ready divide handshake and serves DIV/DIVU.
- Latches operands at start, runs WIDTH iterations, applies sign correction, then returns {remainder, quotient} with ready_o held high until EX releases start_i.
- Supports annul from the pipeline (flush/exception).

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH bits.

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
opdata1_i  input  WIDTH  dividend; sampled with start
opdata2_i  input  WIDTH  divisor; sampled with start
start_i  input  1  request; EX holds it high until it has observed ready_o=1
annul_i  input  1  abort the current operation
result_o  output  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}
ready_o  output  1  result valid; stays high while in DONE
busy_o  output  1  high in CALC/BYZERO

Behaviour:
- Reset: state=IDLE, ready_o=0, busy_o=0, result_o=0, internal counter/regs=0. A reset mid-operation aborts immediately with no result.
- All outputs are registered.

States: IDLE, BYZERO, CALC, DONE.

IDLE:
- If start_i=1 and annul_i=0:
  - Latch signed_div_i.
  - Latch |opdata1_i| and |opdata2_i| (absolute value only when signed).
  - Latch sign_q = op1[W-1]^op2[W-1] and sign_r = op1[W-1] (both only when signed, else 0).
  - If opdata2_i=0, go to BYZERO; otherwise clear counter and go to CALC.
- Otherwise remain in IDLE.

CALC:
- Each cycle:
  - Shift the {partial remainder, dividend} register left by 1.
  - Trial-subtract the divisor from the upper W+1 bits.
  - If the result is non-negative, keep the difference and set quotient LSB=1; otherwise restore and set the LSB to 0.
  - Increment the counter.
- After the WIDTH-th iteration, go to DONE.
- On entry to DONE:
  - result_o = {sign_r ? -rem : rem, sign_q ? -quo : quo}.
  - ready_o=1.

BYZERO:
- One cycle, then DONE with result_o = 0 (fixed team choice; the ISA leaves HI/LO undefined).

DONE:
- ready_o=1 and result_o stable.
- If start_i=0, go to IDLE and ready_o=0 next cycle. result_o keeps its value until the next completion or reset.
- If start_i stays 1, remain in DONE. A new operation requires start_i to go low first.

Annul:
- annul_i=1 in CALC, BYZERO or DONE → IDLE next edge, ready_o=0, result_o unchanged.
- annul_i has priority over start_i and over completion in the same cycle.

Latency:
- start_i is first sampled high at edge N; ready_o rises at edge N+WIDTH+1 (33 for WIDTH=32).
- For a zero divisor, ready_o rises at N+2.
- Operand or sign changes on the inputs during CALC/DONE are ignored.

Arithmetic:
- Absolute value of the most negative number is 2^(W-1), held unsigned in W bits.
- 0x80000000 / 0xFFFFFFFF (signed) → quotient 0x80000000, remainder 0. No trap.
- Quotient truncates toward zero; the remainder takes the sign of the dividend.

busy_o = (state==CALC || state==BYZERO).

Test Plan:
- Unsigned 100/7: start_i=1 with op1=0x64, op2=7, signed=0 → ready_o high exactly 33 cycles after start is first sampled; result_o=0x00000002_0000000E. Drop start → ready_o=0 next cycle.
- Signed -7/2: op1=0xFFFFFFF9, op2=2, signed=1 → result_o=0xFFFFFFFF_FFFFFFFD. Same op with signed=0 → result_o=0x00000001_7FFFFFFC.
- Boundaries, signed:
  - 0x80000000/0xFFFFFFFF → 0x00000000_80000000.
  - 0x80000000/1 → 0x00000000_80000000.
  - 7/-7 → 0x00000000_FFFFFFFF.
- Divide by zero: op2=0 → ready_o high 2 cycles after start, result_o=0, and busy_o high for exactly 1 cycle.
- Annul and reset:
  - annul_i pulsed at iteration 10 → IDLE, ready_o never rises; a new start of 9/3 then yields 0x00000000_00000003 in 33 cycles.
  - rst asserted mid-CALC → all outputs 0 next cycle.
- Hold, ignore and back-to-back:
  - Keep start_i high for 5 cycles in DONE → ready_o and result_o stay stable throughout.
  - Changing opdata1_i/opdata2_i during CALC does not alter the result.
  - A back-to-back op after start_i drops for 1 cycle completes correctly.
